uart_loader: RTL
================

# uart_loader

Receives a program image over the `uart_serial` line while `flash` is high and writes it, one 32-bit word at a time, into the core's instruction memory. Sits directly downstream of the `uart_serial`/`flash` pins inside `top_sim`, upstream of the instruction memory write port. While loading, it holds the core in reset.

## Interface
Parameters:
- `CLKS_PER_BIT`, 4: clock cycles per UART bit. Must be ≥ 4.
- `ADDR_WIDTH`, 32: width of the byte write address.

Ports:
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  synchronous reset, active-high.
- `uart_serial`  input  1  UART RX line, 8N1, LSB first, idle high.
- `flash`  input  1  load enable; high means the image is being loaded.
- `wr_en`  output  1  one-cycle instruction-memory write strobe.
- `wr_addr`  output  ADDR_WIDTH  byte address of the write; always word-aligned.
- `wr_data`  output  32  little-endian assembled word.
- `core_hold`  output  1  keeps the core in reset.
- `frame_err`  output  1  one-cycle pulse when a stop bit is sampled low.

## Operation
- Reset values:
  - `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `frame_err` = 0.
  - `core_hold` = 1.
  - RX FSM in `ARM`; byte counter = 0.
- RX FSM (`uart_rx`):
  - `ARM`: wait until the line has been high for `CLKS_PER_BIT` consecutive cycles, then go to `IDLE`. This prevents a line held low from reset from decoding as bytes.
  - `IDLE`: a sampled 0 moves to `START` and clears the bit-timer.
  - `START`: at timer = `CLKS_PER_BIT/2 - 1`, resample the line.
    - Still 0: go to `DATA` and reset the timer.
    - Now 1: treat as a glitch and return to `IDLE`.
  - `DATA`: sample every `CLKS_PER_BIT` cycles, shifting in 8 bits LSB first, then go to `STOP`.
  - `STOP`: sample after `CLKS_PER_BIT` cycles.
    - 1: pulse `byte_valid` with the byte and go to `IDLE`.
    - 0: pulse `frame_err`, drop the byte and go to `ARM`.
- Input is passed through a 2-flop synchroniser before the FSM.
- Loader:
  - While `flash` = 1, each `byte_valid` places the byte into lane `byte_cnt` (lane 0 = bits 7:0). `byte_cnt` is 2 bits and wraps.
  - When lane 3 is filled:
    - `wr_en` pulses for one cycle.
    - `wr_data` = the assembled word, `wr_addr` = the current address.
    - The address then advances by 4 (modulo 2^ADDR_WIDTH).
  - `byte_valid` while `flash` = 0 is discarded.
- `flash` edges (detected on a registered copy):
  - Rising edge: `wr_addr` → 0, `byte_cnt` → 0, assembly register cleared.
  - Falling edge: a partial word (`byte_cnt` ≠ 0) is discarded without any write.
  - A `byte_valid` coinciding with the rising edge is the first byte of the new image.
- `core_hold` = registered (`rst` | `flash`). It deasserts 1 cycle after `flash` falls, never in the same cycle as a `wr_en`.
- Reset mid-byte or mid-word abandons all state. The FSM re-arms via `ARM`.

## Timing
- `byte_valid` is asserted the cycle after the stop-bit sample. The stop bit is sampled at roughly 9.5 bit-times + 2 synchroniser cycles after the start edge.
- `wr_en` is asserted the cycle after the 4th `byte_valid`. `wr_data`/`wr_addr` are valid only while `wr_en` = 1, and are held otherwise.
- Minimum gap between `wr_en` pulses is 4 frames.
- Back-to-back frames with no idle between the stop bit and the next start bit must be accepted.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum (`ARM`, `IDLE`, `START`, `DATA`, `STOP`).
  - `UART_DATA_BITS` = 8 and `WORD_BYTES` = 4 constants.
- Sub-module `uart_rx`: synchroniser + RX FSM, producing `byte_valid`, `byte_data` and `frame_err`.
- `uart_loader` instantiates `uart_rx` and contains the assembly/address logic.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.
- Line held 0 from reset with `flash` = 0 → no `byte_valid`, no `frame_err`, and `core_hold` = 1 while `rst` = 1, then 0.
- `flash` = 1, idle 1 for 8 cycles, send 0x13 0x00 0x00 0x00 → exactly one `wr_en`, with `wr_addr` = 0x0, `wr_data` = 0x00000013.
- Continue with bytes 0x93 0x00 0x10 0x00, sent back-to-back with no idle → `wr_en` with `wr_addr` = 0x4, `wr_data` = 0x00100093.
- Send 2 bytes, drop `flash`, raise `flash` again, then send 4 bytes AA BB CC DD → no write for the partial word, then `wr_addr` = 0x0, `wr_data` = 0xDDCCBBAA.
- Frame with stop bit driven 0 → `frame_err` pulses once, no byte is counted, and a subsequent valid frame decodes only after the line is high for 4 cycles.
- Assert `rst` in the middle of the 3rd byte → all outputs return to reset values, and the next 4 good bytes write to `wr_addr` = 0x0.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART program loader: receiver FSM state
// encoding, frame/word sizing constants and a small lane-select helper.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int WORD_BYTES     = 4;

  // Receiver states. ARM is the post-reset / post-error state that insists on
  // a stretch of idle-high line before any start bit is believed.
  typedef enum logic [2:0] {
    ARM   = 3'd0,
    IDLE  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } rx_state_t;

  // True when the given byte counter value addresses the final lane of a word.
  function automatic logic isLastLane(input logic [1:0] laneIdx);
    return laneIdx == 2'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// ---------------------------------------------------------------------------
// uart_loader_if
// Bundles the loader's pin-side inputs and instruction-memory write port.
//   uart_serial  UART RX line (8N1, LSB first, idle high)
//   flash        load enable
//   wr_en        one-cycle write strobe
//   wr_addr      word-aligned byte address
//   wr_data      little-endian assembled word
//   core_hold    keeps the core in reset
//   frame_err    one-cycle pulse on a low stop bit
// master: the loader (drives the write port), slave: the environment.
// ---------------------------------------------------------------------------
interface uart_loader_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  uart_serial;
  logic                  flash;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  core_hold;
  logic                  frame_err;

  modport master (
    input  uart_serial,
    input  flash,
    output wr_en,
    output wr_addr,
    output wr_data,
    output core_hold,
    output frame_err
  );

  modport slave (
    output uart_serial,
    output flash,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  core_hold,
    input  frame_err
  );

endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Two-flop synchroniser followed by an 8N1 receiver FSM.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   i_serial      asynchronous UART RX line
//   o_byteValid   one-cycle pulse, o_byteData valid with it
//   o_byteData    received byte
//   o_frameErr    one-cycle pulse when the stop bit samples low
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_serial,
  output logic                      o_byteValid,
  output logic [UART_DATA_BITS-1:0] o_byteData,
  output logic                      o_frameErr
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  logic                      r_sync1;
  logic                      r_sync2;
  logic                      w_rx;
  rx_state_t                 r_state;
  logic [TW-1:0]             r_timer;
  logic [TW-1:0]             r_armCnt;
  logic [2:0]                r_bitIdx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_byteValid;
  logic [UART_DATA_BITS-1:0] r_byteData;
  logic                      r_frameErr;

  // Synchroniser flops reset low so a line stuck low from reset never looks
  // like a run of idle-high samples to the ARM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_serial;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  // Receiver FSM. START checks the middle of the start bit, after which every
  // DATA/STOP sample lands a full bit-time later, i.e. mid-bit. The STOP state
  // returns to IDLE the cycle after its sample so a start bit immediately
  // following the stop bit is still caught on its leading edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARM;
      r_timer     <= '0;
      r_armCnt    <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_byteValid <= 1'b0;
      r_byteData  <= '0;
      r_frameErr  <= 1'b0;
    end else begin
      r_byteValid <= 1'b0;
      r_frameErr  <= 1'b0;
      case (r_state)
        ARM: begin
          if (!w_rx) begin
            r_armCnt <= '0;
          end else if (r_armCnt == BIT_LAST) begin
            r_armCnt <= '0;
            r_state  <= IDLE;
          end else begin
            r_armCnt <= r_armCnt + 1'b1;
          end
        end
        IDLE: begin
          if (!w_rx) begin
            r_timer <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (r_timer == HALF_LAST) begin
            r_timer  <= '0;
            r_bitIdx <= '0;
            r_state  <= w_rx ? IDLE : DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DATA: begin
          if (r_timer == BIT_LAST) begin
            r_timer <= '0;
            r_shift <= {w_rx, r_shift[UART_DATA_BITS-1:1]};
            if (r_bitIdx == 3'(UART_DATA_BITS - 1)) begin
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        STOP: begin
          if (r_timer == BIT_LAST) begin
            r_timer <= '0;
            if (w_rx) begin
              r_byteValid <= 1'b1;
              r_byteData  <= r_shift;
              r_state     <= IDLE;
            end else begin
              r_frameErr <= 1'b1;
              r_armCnt   <= '0;
              r_state    <= ARM;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state  <= ARM;
          r_armCnt <= '0;
        end
      endcase
    end
  end

  assign o_byteValid = r_byteValid;
  assign o_byteData  = r_byteData;
  assign o_frameErr  = r_frameErr;

endmodule

// File: rtl/uart_loader.sv
// ---------------------------------------------------------------------------
// uart_loader
// Receives a program image over UART while flash is high and writes it to
// instruction memory one little-endian 32-bit word at a time, holding the
// core in reset while loading.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   uart_loader_if.master: uart_serial/flash in, write port,
//         core_hold and frame_err out
// ---------------------------------------------------------------------------
module uart_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic          clk,
  input  logic          rst,
  uart_loader_if.master bus
);

  logic                      w_byteValid;
  logic [UART_DATA_BITS-1:0] w_byteData;
  logic                      w_frameErr;
  logic                      w_flashRise;
  logic                      w_flashFall;

  logic                      r_flashQ;
  logic [1:0]                r_byteCnt;
  logic [23:0]               r_asm;
  logic [ADDR_WIDTH-1:0]     r_nextAddr;
  logic                      r_wrEn;
  logic [ADDR_WIDTH-1:0]     r_wrAddr;
  logic [31:0]               r_wrData;
  logic                      r_coreHold;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_serial    (bus.uart_serial),
    .o_byteValid (w_byteValid),
    .o_byteData  (w_byteData),
    .o_frameErr  (w_frameErr)
  );

  assign w_flashRise = bus.flash & ~r_flashQ;
  assign w_flashFall = ~bus.flash & r_flashQ;

  // Word assembly. A rising flash edge restarts the image at address 0 and
  // still accepts a byte arriving in the same cycle as lane 0. A falling edge
  // throws away any partial word so a later image starts aligned. Only the
  // first three lanes are stored; the fourth goes straight into the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flashQ   <= 1'b0;
      r_byteCnt  <= '0;
      r_asm      <= '0;
      r_nextAddr <= '0;
      r_wrEn     <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
    end else begin
      r_flashQ <= bus.flash;
      r_wrEn   <= 1'b0;
      if (w_flashRise) begin
        r_nextAddr <= '0;
        r_wrAddr   <= '0;
        if (w_byteValid) begin
          r_asm     <= {16'h0000, w_byteData};
          r_byteCnt <= 2'd1;
        end else begin
          r_asm     <= '0;
          r_byteCnt <= '0;
        end
      end else if (w_flashFall) begin
        r_asm     <= '0;
        r_byteCnt <= '0;
      end else if (bus.flash && w_byteValid) begin
        r_byteCnt <= r_byteCnt + 1'b1;
        if (isLastLane(r_byteCnt)) begin
          r_wrEn     <= 1'b1;
          r_wrAddr   <= r_nextAddr;
          r_wrData   <= {w_byteData, r_asm};
          r_nextAddr <= r_nextAddr + ADDR_WIDTH'(WORD_BYTES);
          r_asm      <= '0;
        end else begin
          case (r_byteCnt)
            2'd0:    r_asm[7:0]   <= w_byteData;
            2'd1:    r_asm[15:8]  <= w_byteData;
            default: r_asm[23:16] <= w_byteData;
          endcase
        end
      end
    end
  end

  // Core hold follows flash by one cycle, so any write issued on the last
  // loading cycle still lands while the core is held.
  always_ff @(posedge clk) begin
    r_coreHold <= rst | bus.flash;
  end

  assign bus.wr_en     = r_wrEn;
  assign bus.wr_addr   = r_wrAddr;
  assign bus.wr_data   = r_wrData;
  assign bus.core_hold = r_coreHold;
  assign bus.frame_err = w_frameErr;

endmodule
